sync_bus_tx: RTL and testbench
==============================

// Module: sync_bus_tx
// PURPOSE
//  Source-side launcher for the strobe-qualified bus synchronizer: captures a WIDTH-bit word,
//  holds it stable on tx_data, raises tx_req after a setup delay, and runs a 4-phase req/ack
//  handshake with the destination domain. tx_ack is asynchronous and is synchronized internally.
//  Sits in the source clock domain and drives the data/strobe pair the receiver captures.
// PARAMETERS
//  WIDTH        8    data word width
//  SYNC_STAGES  2    flip-flop stages on tx_ack (>=2)
//  HOLD_CYCLES  2    cycles tx_data is stable before tx_req rises (>=1)
//  TIMEOUT      255  max cycles spent in REQ or RELEASE before abort; 0 disables the timeout
// PORTS
//  clk       in   1      source-domain clock
//  rst       in   1      synchronous reset, active-high
//  in_valid  in   1      new word offered
//  in_data   in   WIDTH  word to send
//  in_ready  out  1      1 only in IDLE; the word is accepted on in_valid&in_ready at the clk edge
//  tx_data   out  WIDTH  registered launch data, changes only on accept
//  tx_req    out  1      registered request/strobe to the destination domain
//  tx_ack    in   1      asynchronous acknowledge from the destination domain
//  done      out  1      1-cycle pulse when a handshake completes cleanly
//  err       out  1      1-cycle pulse on timeout abort
//  err_cnt   out  8      saturating count of timeout aborts (stays at 255)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, tx_data=0, tx_req=0, done=0, err=0, err_cnt=0,
//   sync FFs=0, counters=0. Reset mid-handshake drops tx_req on that edge; there is no drain.
//  ack_s = tx_ack after SYNC_STAGES FFs. It is the only form of ack used by the FSM.
//  FSM:
//   IDLE:    in_ready=1. On accept: tx_data<=in_data, hold_cnt<=0, go to SETUP. in_valid
//            outside IDLE is ignored and causes no capture.
//   SETUP:   tx_req=0. When hold_cnt==HOLD_CYCLES-1: tx_req<=1, to_cnt<=0, go to REQ.
//   REQ:     tx_req=1. ack_s=1 -> tx_req<=0, to_cnt<=0, go to RELEASE.
//            Timeout -> tx_req<=0, err pulse, err_cnt+1, go to RELEASE.
//   RELEASE: tx_req=0. ack_s=0 -> go to IDLE; done pulses only if no timeout occurred in this
//            transaction. Timeout here -> err pulse, err_cnt+1, go to IDLE.
//  Timeout fires when to_cnt==TIMEOUT-1 and the exit condition is false. If ack_s and expiry
//   occur in the same cycle, the ack wins.
//  Latency: accept at edge N -> tx_req=1 after edge N+HOLD_CYCLES. A rising tx_ack is seen by
//   the FSM SYNC_STAGES..SYNC_STAGES+1 edges later. Clean round trip >= HOLD_CYCLES+2*SYNC_STAGES+2.
//  Back-to-back: in_ready rises the cycle after the RELEASE exit, so the next accept is possible
//   one cycle after done.
//  tx_data is stable from accept until the next accept. This is the receiver's capture guarantee.
//  ack_s activity in IDLE or SETUP is ignored. A stale ack cannot satisfy REQ because the FSM
//   passes through RELEASE, which waits for ack_s=0.
//  Counter widths: hold_cnt uses $clog2(HOLD_CYCLES+1) bits, to_cnt uses $clog2(TIMEOUT+1) bits.
//   err_cnt saturates at 8'hFF.
// STRUCTURE
//  Shared include sync_pkg.vh holds:
//   - state localparams ST_IDLE=2'd0, ST_SETUP=2'd1, ST_REQ=2'd2, ST_RELEASE=2'd3
//   - default width and stage constants shared with the receiver.
//  Sub-module sync_ff_chain (params STAGES, RST_VAL=0) synchronizes tx_ack and is reused on the
//   receive side. All other logic is one FSM with registered outputs.
// TESTING
//  1 rst=1 for 3 cycles, then 0 -> in_ready=1, tx_req=0, tx_data=8'h00, err_cnt=0.
//  2 in_data=8'hA5 accepted at edge N; loopback ack with 3-cycle delay -> tx_req=1 from edge N+2,
//    tx_data=8'hA5 held throughout, exactly one done pulse, in_ready=1 the cycle after.
//  3 Offer 8'h3C while busy -> ignored; tx_data stays 8'hA5. 8'h3C is accepted only after in_ready=1.
//  4 tx_ack held 0, TIMEOUT=255 -> tx_req falls 255 cycles after it rose, err pulse, err_cnt=1,
//    no done, return to IDLE.
//  5 tx_ack stuck at 1 from before the request -> REQ exits once, then RELEASE times out,
//    err_cnt=2; releasing tx_ack allows a clean next transfer.
//  6 Assert rst during REQ -> tx_req=0 and tx_data=0 at that edge; next transfer of 8'hFF succeeds.

Source files
------------

// File: rtl/sync_bus_tx_pkg.sv
// -----------------------------------------------------------------------------
// sync_bus_tx_pkg
// Shared definitions for the strobe-qualified bus synchronizer (transmit and
// receive sides): FSM state encoding, default word width / stage count, the
// error-counter ceiling and a counter-width helper.
// -----------------------------------------------------------------------------
package sync_bus_tx_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_REQ     = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_e;

    // Bits needed to hold 0..max_val; never less than one bit so a disabled
    // (zero) limit still yields a legal vector.
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_bus_tx_sync_ff_chain.sv
// -----------------------------------------------------------------------------
// sync_ff_chain
// Multi-flop synchronizer for a single asynchronous level. Shared between the
// transmit side (tx_ack) and the receive side (request strobe).
// Ports:
//   clk  in   destination-domain clock
//   rst  in   synchronous reset, active-high; all stages load RST_VAL
//   d    in   asynchronous input level
//   q    out  synchronized level, STAGES clk edges after d settles
// -----------------------------------------------------------------------------
module sync_ff_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d};
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its neighbour held before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/sync_bus_tx.sv
// -----------------------------------------------------------------------------
// sync_bus_tx
// Source-side launcher of the strobe-qualified bus synchronizer. Captures a
// word, holds it on tx_data, raises tx_req after HOLD_CYCLES of setup, then
// runs a 4-phase req/ack handshake with the destination domain. Each of the
// REQ and RELEASE phases is guarded by an optional timeout.
// Ports:
//   clk       in   source-domain clock
//   rst       in   synchronous reset, active-high
//   in_valid  in   word offered
//   in_data   in   word to send
//   in_ready  out  high only in IDLE; accept = in_valid & in_ready at clk edge
//   tx_data   out  launch data, changes only on accept
//   tx_req    out  registered request/strobe
//   tx_ack    in   asynchronous acknowledge (synchronized internally)
//   done      out  1-cycle pulse on a clean handshake completion
//   err       out  1-cycle pulse on a timeout abort
//   err_cnt   out  saturating count of timeout aborts
// -----------------------------------------------------------------------------
module sync_bus_tx
    import sync_bus_tx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             tx_ack,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int TO_W   = cnt_width(TIMEOUT);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    tx_state_e         state_q,     state_d;
    logic [WIDTH-1:0]  tx_data_q,   tx_data_d;
    logic              tx_req_q,    tx_req_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic              done_q,      done_d;
    logic              err_q,       err_d;
    logic [7:0]        err_cnt_q,   err_cnt_d;
    // Remembers a REQ-phase timeout so the following RELEASE exit is not
    // reported as a clean completion.
    logic              timed_out_q, timed_out_d;

    logic ack_s;
    logic to_expired;

    sync_ff_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_ack_sync (
        .clk (clk),
        .rst (rst),
        .d   (tx_ack),
        .q   (ack_s)
    );

    assign to_expired = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_req_d    = tx_req_q;
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = to_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        timed_out_d = timed_out_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_req_d = 1'b0;
                if (in_valid) begin
                    tx_data_d   = in_data;
                    hold_cnt_d  = '0;
                    timed_out_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    tx_req_d = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ST_REQ;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end

            ST_REQ: begin
                // ack wins over a simultaneous expiry.
                if (ack_s) begin
                    tx_req_d = 1'b0;
                    to_cnt_d = '0;
                    state_d  = ST_RELEASE;
                end else if (to_expired) begin
                    tx_req_d    = 1'b0;
                    to_cnt_d    = '0;
                    err_d       = 1'b1;
                    timed_out_d = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                    state_d     = ST_RELEASE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                // Waiting for ack_s low here is what keeps a stale ack from
                // satisfying the next request.
                if (!ack_s) begin
                    done_d  = !timed_out_q;
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_req_q    <= 1'b0;
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_req_q    <= tx_req_d;
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign tx_data  = tx_data_q;
    assign tx_req   = tx_req_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_sync_bus_tx.sv
// -----------------------------------------------------------------------------
// tb_sync_bus_tx
// Self-checking bench for sync_bus_tx. tx_ack comes from a loopback of tx_req
// delayed by a selectable number of negedges, or is forced to a level.
// Accepted words are queued with their expected outcome and matched against
// each done/err pulse.
// -----------------------------------------------------------------------------
module tb_sync_bus_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack;
    logic       done;
    logic       err;
    logic [7:0] err_cnt;

    sync_bus_tx #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .HOLD_CYCLES (2),
        .TIMEOUT     (255)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .tx_ack   (tx_ack),
        .done     (done),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       is_err;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [7:0] data;
        int         ack_dly;
        int         exp_cycles;
    } vec_t;

    // ack model
    logic       loop_en   = 1'b1;
    logic       ack_force = 1'b0;
    int         ack_dly   = 3;
    logic [7:0] ack_pipe  = '0;

    always @(negedge clk) begin
        ack_pipe = {ack_pipe[6:0], tx_req};
        tx_ack   = loop_en ? ack_pipe[ack_dly-1] : ack_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each completed transaction ends in exactly one done or err.
    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (done) done_cnt++;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: done=%0b err=%0b with nothing pending", done, err);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("sb_data", {24'h0, tx_data}, {24'h0, e.data});
                check("sb_kind_err", {31'h0, err}, {31'h0, e.is_err});
                check("sb_kind_done", {31'h0, done}, {31'h0, ~e.is_err});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a word and return 1 ns after the accepting edge.
    task automatic send(input logic [7:0] d, input logic exp_err, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, "_ready"}, {31'h0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        sb_q.push_back('{d, exp_err});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for a done/err pulse; cycles counts negedges including the pulse.
    task automatic wait_end(input int budget, input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(done || err) && cycles < budget);
        check({name, "_completed"}, {31'h0, done | err}, 32'd1);
        #1;
    endtask

    vec_t vecs[5];
    int   cyc;
    int   d0;
    int   hold_bad;
    int   high_cyc;
    logic [7:0] exp_err_cnt;

    initial begin
        vecs[0] = '{8'h01, 1, 9};
        vecs[1] = '{8'h80, 2, 11};
        vecs[2] = '{8'h55, 3, 13};
        vecs[3] = '{8'hAA, 5, 17};
        vecs[4] = '{8'hFE, 1, 9};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_err_cnt = 8'd0;

        // 1: reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'h0, in_ready}, 32'd1);
        check("rst_tx_req",   {31'h0, tx_req},   32'd0);
        check("rst_tx_data",  {24'h0, tx_data},  32'h00);
        check("rst_err_cnt",  {24'h0, err_cnt},  32'd0);
        check("rst_done",     {31'h0, done},     32'd0);

        // 2 + 3: A5 with 3-cycle loopback; 3C offered while busy
        ack_dly = 3;
        d0 = done_cnt;
        send(8'hA5, 1'b0, "t2");
        in_valid = 1'b1;
        in_data  = 8'h3C;
        cyc = 0;
        hold_bad = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) check("t2_req_low_n1", {31'h0, tx_req}, 32'd0);
            if (cyc == 3) check("t2_req_high_n2", {31'h0, tx_req}, 32'd1);
            if (tx_data !== 8'hA5) hold_bad++;
        end while (!done && cyc < 100);
        #1;
        check("t2_hold_a5", hold_bad, 0);
        check("t2_cycles", cyc, 13);
        check("t2_one_done", done_cnt - d0, 1);
        check("t2_ready_after", {31'h0, in_ready}, 32'd1);
        sb_q.push_back('{8'h3C, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_accept_3c", {24'h0, tx_data}, 32'h3C);
        wait_end(100, "t3", cyc);
        check("t3_tx_data", {24'h0, tx_data}, 32'h3C);
        idle(10);

        // Table of clean transfers at varying ack delays
        for (int i = 0; i < 5; i++) begin
            ack_dly = vecs[i].ack_dly;
            idle(10);
            d0 = done_cnt;
            send(vecs[i].data, 1'b0, "vec");
            wait_end(100, "vec", cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check($sformatf("vec%0d_done", i), done_cnt - d0, 1);
            check($sformatf("vec%0d_data", i), {24'h0, tx_data}, {24'h0, vecs[i].data});
            check($sformatf("vec%0d_err_cnt", i), {24'h0, err_cnt}, {24'h0, exp_err_cnt});
        end
        idle(10);

        // 4: ack held low -> REQ timeout
        loop_en   = 1'b0;
        ack_force = 1'b0;
        d0 = done_cnt;
        send(8'h5A, 1'b1, "t4");
        cyc = 0;
        while (!tx_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_req_rose", {31'h0, tx_req}, 32'd1);
        high_cyc = 0;
        while (tx_req && high_cyc < 400) begin
            @(negedge clk);
            high_cyc++;
        end
        check("t4_req_high_cycles", high_cyc, 255);
        check("t4_err_pulse", {31'h0, err}, 32'd1);
        exp_err_cnt = 8'd1;
        check("t4_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err_cnt});
        @(negedge clk);
        check("t4_err_single", {31'h0, err}, 32'd0);
        check("t4_idle", {31'h0, in_ready}, 32'd1);
        check("t4_no_done", done_cnt - d0, 0);

        // 5: ack stuck high -> RELEASE timeout, then recovery
        ack_force = 1'b1;
        idle(5);
        d0 = done_cnt;
        send(8'h77, 1'b1, "t5");
        wait_end(600, "t5", cyc);
        exp_err_cnt = 8'd2;
        check("t5_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err_cnt});
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_idle", {31'h0, in_ready}, 32'd1);
        ack_force = 1'b0;
        loop_en   = 1'b1;
        ack_dly   = 2;
        idle(10);
        d0 = done_cnt;
        send(8'h81, 1'b0, "t5b");
        wait_end(100, "t5b", cyc);
        check("t5b_done", done_cnt - d0, 1);
        check("t5b_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err_cnt});
        idle(10);

        // 6: reset during REQ
        send(8'h42, 1'b0, "t6");
        cyc = 0;
        while (!tx_req && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_in_req", {31'h0, tx_req}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_req", {31'h0, tx_req}, 32'd0);
        check("t6_rst_data", {24'h0, tx_data}, 32'h00);
        check("t6_rst_err_cnt", {24'h0, err_cnt}, 32'd0);
        sb_q.delete();
        exp_err_cnt = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        idle(10);
        d0 = done_cnt;
        send(8'hFF, 1'b0, "t6b");
        wait_end(100, "t6b", cyc);
        check("t6b_done", done_cnt - d0, 1);
        check("t6b_data", {24'h0, tx_data}, 32'hFF);
        check("t6b_err_cnt", {24'h0, err_cnt}, {24'h0, exp_err_cnt});

        idle(5);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
